// File: rtl/accel_pipe_ctrl_if.sv
// -----------------------------------------------------------------------------
// accel_pipe_ctrl_if
// Bundles every signal between the pipeline controller and the rest of the
// crypto CPU: memory stall flags, branch/halt status, accelerator request/done
// pulses, timeout limit, and the controller's outputs.
//   master : the controller (accel_pipe_ctrl) drives acc_int, acc_id,
//            acc_timeout, resume_pulse, stage_wren, stage_flush, cpu_done
//   slave  : the CPU side, which drives the stall, branch, halt, request,
//            done and timeout_limit inputs
// -----------------------------------------------------------------------------
interface accel_pipe_ctrl_if #(
   parameter int NUM_STAGES = 4,
   parameter int NUM_ACC    = 3,
   parameter int TMO_W      = 16
);
   localparam int ID_W = (NUM_ACC > 1) ? $clog2(NUM_ACC) : 1;

   logic                  imem_stall;
   logic                  dmem_stall;
   logic                  branch_taken;
   logic                  halt_wb;
   logic [NUM_ACC-1:0]    acc_req;
   logic [NUM_ACC-1:0]    acc_done;
   logic [TMO_W-1:0]      timeout_limit;
   logic [NUM_ACC-1:0]    acc_int;
   logic [ID_W-1:0]       acc_id;
   logic                  acc_timeout;
   logic                  resume_pulse;
   logic [NUM_STAGES-1:0] stage_wren;
   logic [NUM_STAGES-1:0] stage_flush;
   logic                  cpu_done;

   modport master (
      input  imem_stall, dmem_stall, branch_taken, halt_wb,
             acc_req, acc_done, timeout_limit,
      output acc_int, acc_id, acc_timeout, resume_pulse,
             stage_wren, stage_flush, cpu_done
   );

   modport slave (
      output imem_stall, dmem_stall, branch_taken, halt_wb,
             acc_req, acc_done, timeout_limit,
      input  acc_int, acc_id, acc_timeout, resume_pulse,
             stage_wren, stage_flush, cpu_done
   );
endinterface

// File: rtl/accel_pipe_ctrl.sv
// -----------------------------------------------------------------------------
// accel_pipe_ctrl
// Pipeline control for the crypto CPU. Produces per-stage pipeline register
// write enables and flushes, launches one of NUM_ACC accelerator channels at a
// time over an int/done handshake (with an optional timeout), and latches the
// WB-stage halt.
// Ports:
//   clk    : clock
//   rst_n  : asynchronous active-low reset
//   bus    : accel_pipe_ctrl_if.master
//              in : imem_stall, dmem_stall, branch_taken, halt_wb,
//                   acc_req, acc_done, timeout_limit
//              out: acc_int, acc_id, acc_timeout, resume_pulse,
//                   stage_wren ([0]=IfId), stage_flush, cpu_done
// -----------------------------------------------------------------------------
module accel_pipe_ctrl #(
   parameter int NUM_STAGES  = 4,
   parameter int NUM_ACC     = 3,
   parameter int TMO_W       = 16,
   parameter int FLUSH_DEPTH = 1
) (
   input  logic               clk,
   input  logic               rst_n,
   accel_pipe_ctrl_if.master  bus
);
   localparam int ID_W = (NUM_ACC > 1) ? $clog2(NUM_ACC) : 1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WAIT   = 2'd1,
      RESUME = 2'd2,
      HALTED = 2'd3
   } state_t;

   state_t                state;
   logic [NUM_ACC-1:0]    accInt;
   logic [ID_W-1:0]       accId;
   logic                  accTimeout;
   logic                  resumePulse;
   logic                  cpuDone;
   logic [TMO_W-1:0]      counter;

   logic [ID_W-1:0]       reqIdx;
   logic                  doneHit;
   logic                  timeoutHit;
   logic [NUM_STAGES-1:0] wren;
   logic [NUM_STAGES-1:0] flush;

   // Lowest set request index wins: scan from the top so the lowest overwrites.
   always_comb begin
      reqIdx = '0;
      for (int i = NUM_ACC - 1; i >= 0; i--) begin
         if (bus.acc_req[i]) reqIdx = ID_W'(i);
      end
   end

   // Only the done bit of the launched channel counts.
   assign doneHit    = bus.acc_done[accId];
   assign timeoutHit = (bus.timeout_limit != '0) && (counter == bus.timeout_limit);

   // Control FSM with registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         accInt      <= '0;
         accId       <= '0;
         accTimeout  <= 1'b0;
         resumePulse <= 1'b0;
         cpuDone     <= 1'b0;
         counter     <= '0;
      end else begin
         resumePulse <= 1'b0;
         if (bus.halt_wb) begin
            state   <= HALTED;
            accInt  <= '0;
            cpuDone <= 1'b1;
         end else begin
            case (state)
               IDLE: begin
                  if (|bus.acc_req) begin
                     state   <= WAIT;
                     accId   <= reqIdx;
                     accInt  <= NUM_ACC'(1) << reqIdx;
                     counter <= '0;
                  end
               end
               WAIT: begin
                  // done has priority over a timeout landing in the same cycle
                  if (doneHit) begin
                     state       <= RESUME;
                     accInt      <= '0;
                     resumePulse <= 1'b1;
                  end else if (timeoutHit) begin
                     state       <= RESUME;
                     accInt      <= '0;
                     resumePulse <= 1'b1;
                     accTimeout  <= 1'b1;
                  end else if (counter != '1) begin
                     counter <= counter + 1'b1;
                  end
               end
               RESUME: state <= IDLE;
               default: begin
                  state   <= HALTED;
                  accInt  <= '0;
                  cpuDone <= 1'b1;
               end
            endcase
         end
      end
   end

   // Combinational write enables and flushes
   always_comb begin
      wren = '0;
      case (state)
         IDLE: begin
            wren               = {NUM_STAGES{~bus.dmem_stall}};
            wren[0]            = ~bus.imem_stall & ~bus.dmem_stall;
            wren[NUM_STAGES-1] = 1'b1;
         end
         RESUME:  wren = '1;
         default: wren = '0;
      endcase
   end

   always_comb begin
      flush = '0;
      for (int k = 0; k < NUM_STAGES; k++) begin
         if (k < FLUSH_DEPTH) begin
            flush[k] = bus.branch_taken & ~wren[k] & (state != HALTED);
         end
      end
   end

   assign bus.acc_int      = accInt;
   assign bus.acc_id       = accId;
   assign bus.acc_timeout  = accTimeout;
   assign bus.resume_pulse = resumePulse;
   assign bus.cpu_done     = cpuDone;
   assign bus.stage_wren   = wren;
   assign bus.stage_flush  = flush;
endmodule
